// File: rtl/wave_gen_if.sv
// Control and sample bundle for wave_gen.
// The master drives the controls; the generator (slave) returns out and wrap.
interface wave_gen_if #(
  parameter int W = 8
);
  logic         ena;
  logic         sync_in;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic [W-1:0] duty;
  logic [W-1:0] out;
  logic         wrap;

  modport master (
    output ena, sync_in, mode, step, duty,
    input  out, wrap
  );

  modport slave (
    input  ena, sync_in, mode, step, duty,
    output out, wrap
  );
endinterface

// File: rtl/wave_gen.sv
// DDS-style waveform generator: a W-bit phase accumulator shaped into square,
// rising/falling saw or triangle, with mode/step/duty shadowed to period boundaries.
module wave_gen #(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst,
  wave_gen_if.slave bus
);

  logic [W-1:0] phase;
  logic [1:0]   mode_q;
  logic [W-1:0] step_q;
  logic [W-1:0] duty_q;
  logic         armed;
  logic [W-1:0] out_q;
  logic         wrap_q;

  logic [W:0]   sum;
  logic         carry;
  logic         load_shadow;

  function automatic logic [W-1:0] shape(
    input logic [1:0]   m,
    input logic [W-1:0] p,
    input logic [W-1:0] dq
  );
    logic [W-1:0] d;
    d = {p[W-2:0], 1'b0};
    case (m)
      2'd0:    shape = (p < dq) ? '1 : '0;
      2'd1:    shape = p;
      2'd2:    shape = ~p;
      default: shape = p[W-1] ? ~d : d;
    endcase
  endfunction

  assign sum   = {1'b0, phase} + {1'b0, step_q};
  assign carry = sum[W];

  // A sync edge counts as a non-advancing edge, so shadows reload there too.
  assign load_shadow = !armed || !bus.ena || bus.sync_in || carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= '0;
      mode_q <= '0;
      step_q <= '0;
      duty_q <= '0;
      armed  <= 1'b0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (bus.ena) armed <= 1'b1;
      if (load_shadow) begin
        mode_q <= bus.mode;
        step_q <= bus.step;
        duty_q <= bus.duty;
      end
      if (bus.sync_in) begin
        phase  <= '0;
        wrap_q <= 1'b0;
        out_q  <= shape(mode_q, '0, duty_q);
      end else if (bus.ena) begin
        // out uses the pre-update phase, so it trails the accumulator by one cycle.
        phase  <= sum[W-1:0];
        wrap_q <= carry;
        out_q  <= shape(mode_q, phase, duty_q);
      end else begin
        wrap_q <= 1'b0;
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.wrap = wrap_q;

endmodule

// File: doc/wave_gen.md
Name: wave_gen

Overview:
- Parametrised multi-mode periodic waveform generator built on a W-bit phase accumulator (DDS style).
- Output modes: square with programmable duty, rising sawtooth, falling sawtooth and triangle.
- Frequency is set by a per-cycle phase step. A one-cycle wrap pulse marks each period boundary.
- Mode, step and duty pass through shadow registers, so updates take effect only at period boundaries and never corrupt a period in progress.

Parameters:
- W, 8, width of the phase accumulator, step, duty and out; legal range is W ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  advance enable; when low, all state holds.
- sync_in  input  1  synchronous phase clear, used to align multiple channels.
- mode  input  2  waveform select: 0 square, 1 rising saw, 2 falling saw, 3 triangle.
- step  input  W  phase increment added per enabled cycle.
- duty  input  W  square-mode high threshold.
- out  output  W  registered waveform sample.
- wrap  output  1  registered one-cycle pulse when the accumulator wraps.

Behaviour:
- Reset values (asynchronous, rst high): phase=0, mode_q=0, step_q=0, duty_q=0, armed=0, out=0, wrap=0.
- Shadow load: mode_q, step_q and duty_q capture mode, step and duty on any rising edge where armed=0, or ena=0, or the current edge produces a wrap. The captured values are used from the next edge onward.
- armed: set to 1 on the first edge with ena=1 after reset. It is cleared only by rst.
- Phase update, priority order, one rule per edge:
  - rst: async clear of all state.
  - sync_in=1 (regardless of ena): phase<=0, wrap<=0, out<=f(0). Shadows load as if ena=0.
  - ena=1: {carry, phase} <= phase + step_q, computed as a (W+1)-bit sum; wrap<=carry.
  - ena=0: phase and out hold; wrap<=0.
- Output function f(p), using mode_q and duty_q:
  - Square (mode 0): all-ones if p < duty_q (unsigned), else 0. duty_q=0 gives constant 0.
  - Rising saw (mode 1): p.
  - Falling saw (mode 2): bitwise NOT of p.
  - Triangle (mode 3): let d = {p[W-2:0], 1'b0}. If p[W-1]=0, out = d; otherwise out = ~d.
- Latency:
  - On an enabled edge, out <= f(phase), using the pre-update phase. out therefore lags the phase register by one cycle.
  - wrap is asserted in the same cycle that phase holds its post-wrap value.
- Period: 2^W / step_q enabled cycles when step_q divides 2^W; otherwise wraps are irregular and the average period is the same.
- step_q=0: phase freezes, out is constant, wrap is never asserted. This is legal.
- Wrap-around arithmetic: purely modulo 2^W; there is no saturation.
- Simultaneous sync_in and wrap carry: sync_in wins and wrap stays 0.
- Changing mode, step or duty mid-period: no effect until the next wrap edge (or any ena=0 cycle). The first sample of the new mode appears one cycle after the wrap pulse.
- Reset mid-operation: outputs clear immediately, without waiting for a clock edge. After release, armed=0, so the first enabled edge loads fresh shadows.

Test Plan (W=8):
- Square duty: reset, then mode=0, step=1, duty=128, ena=1. Required: out=0xFF for 128 cycles, then 0x00 for 128 cycles; wrap pulses once every 256 enabled cycles, for 1 cycle.
- Rising saw, step 4: mode=1, step=4. Required: out sequence 0,4,8,…,252,0,…; wrap every 64 cycles. Check the 252→0 transition lags the wrap pulse by 1 cycle.
- Triangle: mode=3, step=2. Required: out 0,4,…,252, then 255,251,…,3, then repeats; peak at 252/255; period 128 cycles.
- Deferred update: while running mode 1 with step=1, change mode=2 and step=8 at phase=0x40. Required: the ramp continues to 0xFF, wrap is asserted, then out switches to falling saw with step 8 (255,247,…).
- Hold and sync: deassert ena for 10 cycles mid-ramp, then pulse sync_in.
  - During the hold: out and phase are frozen and wrap=0.
  - After the sync_in edge: phase=0 and out=f(0); the ramp restarts from 0 when ena=1.
- Async reset: assert rst between clock edges mid-ramp. Required: out=0 and wrap=0 immediately. After release with step=16, the first ramp runs 0,16,32,….
